// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op and state encodings for the multiply/divide unit
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  // Same encodings are decoded from funct 0x18..0x1B by the control unit.
  typedef enum logic [1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative multiply/divide unit owning the HI/LO registers
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int ITER  = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(ITER) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

  mdu_state_e state, state_next;

  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   rs_hold;
  logic               is_div, neg_res, neg_rem, dz;

  logic               accept, move_ok;
  logic               in_signed, in_div, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;

  assign accept  = start && (state == IDLE || state == DONE);
  assign move_ok = !start && (state == IDLE || state == DONE);

  // Unsigned ops keep raw operands; signed ops iterate on magnitudes.
  assign in_signed = (op == MDU_MULT) || (op == MDU_DIV);
  assign in_div    = (op == MDU_DIV) || (op == MDU_DIVU);
  assign a_neg     = in_signed && rs_val[WIDTH-1];
  assign b_neg     = in_signed && rt_val[WIDTH-1];
  assign a_mag     = a_neg ? -rs_val : rs_val;
  assign b_mag     = b_neg ? -rt_val : rt_val;

  // Multiply step: acc = {partial product, remaining multiplier bits}.
  logic [WIDTH:0]     mul_upper;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_upper = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand})
                            : {1'b0, acc[2*WIDTH-1:WIDTH]};
  assign mul_next  = {mul_upper, acc[WIDTH-1:1]};

  // Restoring divide step: acc = {remainder, dividend shifting into quotient}.
  logic [WIDTH:0]     rem_shift, rem_diff;
  logic [2*WIDTH-1:0] div_next;
  assign rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, operand};
  assign div_next  = rem_diff[WIDTH] ? {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {rem_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;

  always_comb begin
    prod   = neg_res ? -acc : acc;
    quo    = acc[WIDTH-1:0];
    rem    = acc[2*WIDTH-1:WIDTH];
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (is_div) begin
      if (dz) begin
        fix_hi = rs_hold;
        fix_lo = '1;
      end else begin
        fix_hi = neg_rem ? -rem : rem;
        fix_lo = neg_res ? -quo : quo;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: state_next = start ? CALC : IDLE;
      CALC:       if (cnt == LAST_ITER) state_next = FIXUP;
      FIXUP:      state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      operand     <= '0;
      rs_hold     <= '0;
      is_div      <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      dz          <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_next;
      busy        <= (state_next == CALC) || (state_next == FIXUP);
      done        <= (state_next == DONE);
      div_by_zero <= (state_next == DONE) && dz;
      if (accept) begin
        cnt     <= '0;
        acc     <= in_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
        operand <= in_div ? b_mag : a_mag;
        rs_hold <= rs_val;
        is_div  <= in_div;
        neg_res <= a_neg ^ b_neg;
        neg_rem <= a_neg;
        dz      <= in_div && (rt_val == '0);
      end else if (state == CALC) begin
        cnt <= cnt + 1'b1;
        acc <= is_div ? div_next : mul_next;
      end else if (state == FIXUP) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end else if (move_ok) begin
        if (mthi) hi <= rs_val;
        if (mtlo) lo <= rs_val;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed vector bench for mult_div_unit
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, mthi, mtlo;
  logic [1:0]   op;
  logic [W-1:0] rs_val, rt_val;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  mult_div_unit #(.WIDTH(W), .ITER(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .mthi(mthi), .mtlo(mtlo),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    logic         exp_dbz;
  } vec_t;

  vec_t vecs[11];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Operands are scrambled right after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0; rs_val = ~a; rt_val = ~b;
  endtask

  task automatic wait_done(output int nbusy, output logic seen);
    nbusy = 0;
    seen  = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) nbusy++;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int   nb;
    logic seen;

    vecs[0]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0};
    vecs[1]  = '{MDU_MULT,  32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0};
    vecs[2]  = '{MDU_DIV,   32'hFFFFFFEF, 32'h00000005, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{MDU_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[5]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6]  = '{MDU_DIVU,  32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999, 1'b0};
    vecs[7]  = '{MDU_DIV,   32'h00000011, 32'hFFFFFFFB, 32'h00000002, 32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{MDU_MULTU, 32'h12345678, 32'h00000100, 32'h00000012, 32'h34567800, 1'b0};
    vecs[9]  = '{MDU_DIV,   32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{MDU_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};

    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'd0; rs_val = '0; rt_val = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);

    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
      wait_done(nb, seen);
      check($sformatf("v%0d_done", i), seen, 1);
      check($sformatf("v%0d_busy_cycles", i), nb, 33);
      check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
      check($sformatf("v%0d_dbz", i), div_by_zero, vecs[i].exp_dbz);
      check($sformatf("v%0d_busy_at_done", i), busy, 0);
    end
    @(negedge clk);
    check("done_pulse_low", done, 0);
    check("dbz_pulse_low", div_by_zero, 0);

    // mthi while busy, then a second start mid-CALC; neither may disturb the op.
    issue(MDU_MULTU, 32'h00010000, 32'h00030000);
    repeat (4) @(negedge clk);
    mthi = 1'b1; rs_val = 32'hA5A5A5A5;
    @(negedge clk);
    mthi = 1'b0;
    check("busy_mthi_hi", hi, 32'h00000000);
    check("busy_mthi_lo", lo, 32'h00000001);
    start = 1'b1; op = MDU_DIVU; rs_val = 32'd9; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(nb, seen);
    check("ign_start_done", seen, 1);
    check("ign_start_hi", hi, 32'h00000003);
    check("ign_start_lo", lo, 32'h00000000);
    mthi = 1'b1; rs_val = 32'hA5A5A5A5;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_after_done_hi", hi, 32'hA5A5A5A5);
    check("mthi_after_done_lo", lo, 32'h00000000);
    mthi = 1'b1; mtlo = 1'b1; rs_val = 32'h5A5A5A5A;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    check("mthi_mtlo_hi", hi, 32'h5A5A5A5A);
    check("mthi_mtlo_lo", lo, 32'h5A5A5A5A);

    // start beats mthi/mtlo in the same cycle.
    start = 1'b1; op = MDU_MULTU; rs_val = 32'd2; rt_val = 32'd3; mthi = 1'b1; mtlo = 1'b1;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    check("start_wins_hi", hi, 32'h5A5A5A5A);
    check("start_wins_busy", busy, 1);
    wait_done(nb, seen);
    check("start_wins_cycles", nb, 33);
    check("start_wins_res_hi", hi, 32'h0);
    check("start_wins_res_lo", lo, 32'd6);

    // Back-to-back start accepted from DONE.
    start = 1'b1; op = MDU_DIV; rs_val = 32'hFFFFFFEC; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", busy, 1);
    wait_done(nb, seen);
    check("b2b_cycles", nb, 33);
    check("b2b_hi", hi, 32'hFFFFFFFE);
    check("b2b_lo", lo, 32'hFFFFFFFA);

    // Reset in the middle of a divide aborts it with no done pulse.
    issue(MDU_DIV, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_busy", busy, 0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    check("abort_no_done", seen, 0);
    check("abort_hi_after", hi, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the execute stage, parallel to the ALU.
- Consumes the register-file read values (rs, rt) and a decoded operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- Holds the architectural HI/LO registers, which feed the write-back mux for MFHI/MFLO.
- Asserts busy so the program counter and register-file write can be stalled while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITER, 32, iteration cycles per operation; must equal WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to begin the operation on op.
- op  input  2  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- rs_val  input  WIDTH  multiplicand or dividend.
- rt_val  input  WIDTH  multiplier or divisor.
- mthi  input  1  write rs_val into HI.
- mtlo  input  1  write rs_val into LO.
- busy  output  1  operation in progress; the datapath stalls while high.
- done  output  1  one-cycle pulse; HI/LO hold the new result.
- div_by_zero  output  1  pulses with done when a DIV/DIVU divisor was 0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset is synchronous and active-high: state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, iteration counter=0.
- Reset asserted mid-operation aborts the operation; HI/LO go to 0.
- States and transitions:
  - IDLE: on start, latch op, |rs_val| and |rt_val| (raw values for the unsigned ops), and the sign flags; go to CALC with counter=0.
  - CALC: one iteration per cycle; counter increments; after ITER iterations go to FIXUP.
  - FIXUP: apply the sign correction, write hi/lo, go to DONE.
  - DONE: done=1 and div_by_zero valid for this cycle only. If start is high, behave as IDLE (accept it); otherwise go to IDLE.
- busy = (state==CALC || state==FIXUP), registered.
- Latency: start sampled at edge E0; busy is high for 33 cycles (E0+1 through E33); hi/lo are updated and done=1 in the cycle after E33.
- start while busy: ignored; no queueing.
- Multiply: shift-add over a 2*WIDTH accumulator, one multiplier bit per iteration.
  - Signed result = 64-bit negation when the operand signs differ.
  - hi=result[63:32], lo=result[31:0].
- Divide: restoring division, one quotient bit per iteration.
  - lo=quotient, hi=remainder.
  - Signed: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
- Divide by zero:
  - Still runs the full 33 cycles.
  - Result forced to lo=32'hFFFFFFFF, hi=rs_val as latched at start.
  - div_by_zero=1 together with done.
- Signed overflow (-2^31 / -1): lo=32'h80000000, hi=0. No flag.
- mthi/mtlo:
  - Honoured only in IDLE or DONE with start low; hi/lo take rs_val on the next edge.
  - Both high writes both registers.
  - Ignored while busy.
  - start wins over mthi/mtlo in the same cycle.
- Operand capture: rs_val and rt_val are read only at the accepting edge. Later changes on these inputs have no effect on the operation in flight.
- HI/LO are unchanged between completion and the next write. No change is ever visible before FIXUP completes.

Decomposition:
- Shared package mdu_pkg:
  - op encodings MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU;
  - state encoding IDLE/CALC/FIXUP/DONE;
  - WIDTH default constant.
- The control unit and ALU_control reuse the op encodings when decoding funct 0x18/0x19/0x1A/0x1B/0x11/0x13.
- No sub-module; the FSM, datapath and sign fixup fit in one module.

Test Plan:
- Reset held 2 cycles, then released → hi=0, lo=0, busy=0, done=0.
- MULTU rs=32'hFFFFFFFF, rt=32'h2 → busy for 33 cycles; done pulse; hi=1, lo=32'hFFFFFFFE.
- MULT rs=-7 (32'hFFFFFFF9), rt=6 → hi=32'hFFFFFFFF, lo=32'hFFFFFFD6 (-42).
- DIV rs=-17, rt=5 → lo=-3 (32'hFFFFFFFD), hi=-2 (32'hFFFFFFFE).
- DIVU rs=100, rt=0 → done with div_by_zero=1; lo=32'hFFFFFFFF, hi=100.
- Edge cases:
  - mthi asserted with rs=32'hA5A5A5A5 while busy → hi unchanged.
  - Same mthi after done → hi=32'hA5A5A5A5.
  - Second start mid-CALC → ignored.
  - reset at cycle 10 of DIV → IDLE, hi=lo=0, no done pulse.
